apb_cfg_bridge: RTL and testbench

- Single-clock, parametrised successor to the item-memory configuration bridge.
- Full APB3 slave: setup/access phases, wait states and pslverr.
- Local register window holds the item count and error status.
- A memory window forwards word accesses to the item memory; it adds a configurable base, bounds checking, a write-protect mode and a read-timeout watchdog.

---
 rtl/apb_cfg_bridge.sv | 172 +++++++++++++++++
 tb/tb_apb_cfg_bridge.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cfg_bridge.sv
// APB3 slave with ITEM_COUNT/STATUS registers and a bounds-checked,
// write-protectable window onto an external item memory with a read watchdog.
module apb_cfg_bridge #(
    parameter int MAX_ITEMS = 1024,
    parameter int ADDR_W    = 15,
    parameter int DATA_W    = 32,
    parameter int MEM_BASE  = 'h0100,
    parameter int TIMEOUT   = 16,
    localparam int IDX_W    = $clog2(MAX_ITEMS),
    localparam int CNT_W    = $clog2(MAX_ITEMS + 1)
) (
    input  logic              clk_apb,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] paddr,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [DATA_W-1:0] pwdata,
    input  logic              cfg_mode,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              cfg_read_en,
    output logic [IDX_W-1:0]  cfg_read_addr,
    input  logic [DATA_W-1:0] cfg_read_data,
    input  logic              cfg_read_valid,
    output logic              cfg_write_en,
    output logic [IDX_W-1:0]  cfg_write_addr,
    output logic [DATA_W-1:0] cfg_write_data,
    output logic [CNT_W-1:0]  item_count
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

    localparam int                CMP_W     = (ADDR_W > CNT_W) ? ADDR_W : CNT_W;
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(MEM_BASE);
    localparam logic [DATA_W-1:0] MAX_D     = DATA_W'(MAX_ITEMS);
    localparam logic [CNT_W-1:0]  MAX_C     = CNT_W'(MAX_ITEMS);
    localparam logic [7:0]        TIMEOUT_C = 8'(TIMEOUT);

    state_t            state, state_d;
    logic [7:0]        timer, timer_d;
    logic [7:0]        err_cnt, err_cnt_d;
    logic              last_timeout, last_timeout_d;
    logic [CNT_W-1:0]  count_d;
    logic [DATA_W-1:0] prdata_d, wr_data_d;
    logic              pready_d, pslverr_d, rd_en_d, wr_en_d;
    logic [IDX_W-1:0]  rd_addr_d, wr_addr_d;

    logic [ADDR_W-1:0] word;
    logic [IDX_W-1:0]  idx;
    logic              is_count, is_status, in_window, mem_err, resp_err;

    // Word index into the memory window; only meaningful when in_window.
    assign word      = (paddr - BASE) >> 2;
    assign idx       = word[IDX_W-1:0];
    assign is_count  = (paddr == '0);
    assign is_status = (paddr == ADDR_W'(4));
    assign in_window = (paddr >= BASE);
    assign mem_err   = (paddr[1:0] != 2'b00)
                    || (CMP_W'(word) >= CMP_W'(item_count))
                    || (pwrite && !cfg_mode);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d        = state;
        timer_d        = timer;
        err_cnt_d      = err_cnt;
        last_timeout_d = last_timeout;
        count_d        = item_count;
        prdata_d       = prdata;
        pready_d       = 1'b0;
        pslverr_d      = 1'b0;
        rd_en_d        = 1'b0;
        rd_addr_d      = cfg_read_addr;
        wr_en_d        = 1'b0;
        wr_addr_d      = cfg_write_addr;
        wr_data_d      = cfg_write_data;
        resp_err       = 1'b0;

        case (state)
            IDLE: begin
                if (psel && penable) begin
                    state_d  = RESP;
                    pready_d = 1'b1;
                    if (is_count) begin
                        if (pwrite) count_d = (pwdata > MAX_D) ? MAX_C : pwdata[CNT_W-1:0];
                        else        prdata_d = DATA_W'(item_count);
                    end else if (is_status) begin
                        if (pwrite) begin
                            err_cnt_d      = '0;
                            last_timeout_d = 1'b0;
                        end else begin
                            prdata_d = DATA_W'({last_timeout, err_cnt});
                        end
                    end else if (!in_window || mem_err) begin
                        resp_err = 1'b1;
                    end else if (pwrite) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = idx;
                        wr_data_d = pwdata;
                    end else begin
                        rd_en_d   = 1'b1;
                        rd_addr_d = idx;
                        timer_d   = '0;
                        state_d   = RD_WAIT;
                        pready_d  = 1'b0;
                    end
                end
            end
            RD_WAIT: begin
                // A dropped psel means the master gave up; leave silently.
                if (!psel) begin
                    state_d = IDLE;
                end else if (cfg_read_valid) begin
                    prdata_d = cfg_read_data;
                    state_d  = RESP;
                    pready_d = 1'b1;
                end else if (timer + 8'd1 == TIMEOUT_C) begin
                    prdata_d       = '0;
                    last_timeout_d = 1'b1;
                    resp_err       = 1'b1;
                    state_d        = RESP;
                    pready_d       = 1'b1;
                end else begin
                    timer_d = timer + 8'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (resp_err) begin
            pslverr_d = 1'b1;
            if (err_cnt != 8'hFF) err_cnt_d = err_cnt + 8'd1;
        end
    end

    // NOTE: all state is reset asynchronously; this block only ever uses non-blocking assignments.
    always_ff @(posedge clk_apb or negedge rstn) begin
        if (!rstn) begin
            state          <= IDLE;
            timer          <= '0;
            err_cnt        <= '0;
            last_timeout   <= 1'b0;
            item_count     <= '0;
            prdata         <= '0;
            pready         <= 1'b0;
            pslverr        <= 1'b0;
            cfg_read_en    <= 1'b0;
            cfg_read_addr  <= '0;
            cfg_write_en   <= 1'b0;
            cfg_write_addr <= '0;
            cfg_write_data <= '0;
        end else begin
            state          <= state_d;
            timer          <= timer_d;
            err_cnt        <= err_cnt_d;
            last_timeout   <= last_timeout_d;
            item_count     <= count_d;
            prdata         <= prdata_d;
            pready         <= pready_d;
            pslverr        <= pslverr_d;
            cfg_read_en    <= rd_en_d;
            cfg_read_addr  <= rd_addr_d;
            cfg_write_en   <= wr_en_d;
            cfg_write_addr <= wr_addr_d;
            cfg_write_data <= wr_data_d;
        end
    end

endmodule

// File: tb/tb_apb_cfg_bridge.sv
// Directed bench for apb_cfg_bridge: a transaction-level model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_apb_cfg_bridge;

    localparam int MAX_ITEMS = 1024;
    localparam int ADDR_W    = 15;
    localparam int DATA_W    = 32;
    localparam int MEM_BASE  = 'h0100;
    localparam int TIMEOUT   = 16;

    logic        clk_apb = 1'b0;
    logic        rstn    = 1'b0;
    logic [14:0] paddr   = '0;
    logic        psel    = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite  = 1'b0;
    logic [31:0] pwdata  = '0;
    logic        cfg_mode = 1'b0;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic        cfg_read_en;
    logic [9:0]  cfg_read_addr;
    logic [31:0] cfg_read_data  = '0;
    logic        cfg_read_valid = 1'b0;
    logic        cfg_write_en;
    logic [9:0]  cfg_write_addr;
    logic [31:0] cfg_write_data;
    logic [10:0] item_count;

    apb_cfg_bridge #(
        .MAX_ITEMS(MAX_ITEMS), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .MEM_BASE(MEM_BASE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_apb(clk_apb), .rstn(rstn), .paddr(paddr), .psel(psel),
        .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .cfg_mode(cfg_mode),
        .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .cfg_read_en(cfg_read_en), .cfg_read_addr(cfg_read_addr),
        .cfg_read_data(cfg_read_data), .cfg_read_valid(cfg_read_valid),
        .cfg_write_en(cfg_write_en), .cfg_write_addr(cfg_write_addr),
        .cfg_write_data(cfg_write_data), .item_count(item_count)
    );

    always #5 clk_apb = ~clk_apb;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: valid arrives in the rd_delay-th cycle counting the strobe cycle as 1.
    int          rd_delay  = 0;
    int          late_req  = 0;
    int          late_done = 0;
    logic [31:0] tb_mem [0:1023];
    bit          rsp_pending = 1'b0;
    int          rsp_age     = 0;
    logic [9:0]  rsp_idx     = '0;

    always @(posedge clk_apb) begin
        #1;
        cfg_read_valid = 1'b0;
        cfg_read_data  = 32'hDEAD_BEEF;
        if (cfg_write_en) tb_mem[cfg_write_addr] = cfg_write_data;
        if (cfg_read_en) begin
            rsp_pending = 1'b1;
            rsp_age     = 0;
            rsp_idx     = cfg_read_addr;
        end
        if (rsp_pending) begin
            rsp_age++;
            if (rd_delay != 0 && rsp_age == rd_delay) begin
                cfg_read_valid = 1'b1;
                cfg_read_data  = tb_mem[rsp_idx];
                rsp_pending    = 1'b0;
            end else if (rsp_age > 64) begin
                rsp_pending = 1'b0;
            end
        end else if (late_req != late_done) begin
            late_done++;
            cfg_read_valid = 1'b1;
            cfg_read_data  = 32'h1234_5678;
        end
    end

    // Transaction-level model: registers as integers, responses predicted one cycle ahead.
    int          m_count = 0;
    int          m_err   = 0;
    bit          m_lto   = 1'b0;
    logic [31:0] m_prdata = '0;
    bit          due_resp = 1'b0, due_err = 1'b0, due_rd = 1'b0, due_wr = 1'b0;
    int          due_idx  = 0;
    logic [31:0] due_wdata = '0;
    bit          rd_pending = 1'b0;
    int          rd_age = 0;
    bit          resp_now = 1'b0;
    bit          acc_err = 1'b0;
    int          a_m = 0;
    int          n_rd = 0, n_wr = 0, n_resp = 0;

    always @(negedge clk_apb) begin
        if (!rstn) begin
            m_count = 0; m_err = 0; m_lto = 1'b0; m_prdata = '0;
            due_resp = 1'b0; due_err = 1'b0; due_rd = 1'b0; due_wr = 1'b0;
            rd_pending = 1'b0;
            check("rst_pready", 32'(pready), 32'd0);
            check("rst_rd_en", 32'(cfg_read_en), 32'd0);
            check("rst_wr_en", 32'(cfg_write_en), 32'd0);
            check("rst_item_count", 32'(item_count), 32'd0);
        end else begin
            check("pready", 32'(pready), 32'(due_resp));
            if (due_resp) check("pslverr", 32'(pslverr), 32'(due_err));
            check("prdata", prdata, m_prdata);
            check("item_count", 32'(item_count), 32'(m_count));
            check("rd_en", 32'(cfg_read_en), 32'(due_rd));
            check("wr_en", 32'(cfg_write_en), 32'(due_wr));
            if (due_rd) check("rd_addr", 32'(cfg_read_addr), 32'(due_idx));
            if (due_wr) begin
                check("wr_addr", 32'(cfg_write_addr), 32'(due_idx));
                check("wr_data", cfg_write_data, due_wdata);
            end
            if (cfg_read_en)  n_rd++;
            if (cfg_write_en) n_wr++;
            if (pready)       n_resp++;

            resp_now = due_resp;
            due_resp = 1'b0; due_err = 1'b0; due_rd = 1'b0; due_wr = 1'b0;

            if (rd_pending) begin
                rd_age++;
                if (!psel) begin
                    rd_pending = 1'b0;
                end else if (cfg_read_valid) begin
                    due_resp = 1'b1; m_prdata = cfg_read_data; rd_pending = 1'b0;
                end else if (rd_age == TIMEOUT) begin
                    due_resp = 1'b1; due_err = 1'b1; m_prdata = '0; m_lto = 1'b1;
                    m_err = (m_err < 255) ? m_err + 1 : 255;
                    rd_pending = 1'b0;
                end
            end else if (!resp_now && psel && penable) begin
                a_m = int'(paddr);
                acc_err = 1'b0;
                if (a_m == 0) begin
                    if (pwrite) m_count = (pwdata > MAX_ITEMS) ? MAX_ITEMS : int'(pwdata);
                    else        m_prdata = 32'(m_count);
                end else if (a_m == 4) begin
                    if (pwrite) begin m_err = 0; m_lto = 1'b0; end
                    else        m_prdata = 32'((m_lto ? 256 : 0) + m_err);
                end else if (a_m < MEM_BASE || a_m % 4 != 0 || (a_m - MEM_BASE) / 4 >= m_count
                             || (pwrite && !cfg_mode)) begin
                    acc_err = 1'b1;
                end else if (pwrite) begin
                    due_wr = 1'b1; due_idx = (a_m - MEM_BASE) / 4; due_wdata = pwdata;
                end else begin
                    due_rd = 1'b1; due_idx = (a_m - MEM_BASE) / 4; rd_pending = 1'b1; rd_age = 0;
                end
                if (!rd_pending) begin
                    due_resp = 1'b1;
                    due_err  = acc_err;
                    if (acc_err) m_err = (m_err < 255) ? m_err + 1 : 255;
                end
            end
        end
    end

    // cyc counts access-phase cycles, response cycle included.
    task automatic apb(input bit wr, input int addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output bit err, output int cyc);
        @(posedge clk_apb); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = 15'(addr); pwdata = wdata;
        @(posedge clk_apb); #1;
        penable = 1'b1;
        cyc = 0; rdata = 'x; err = 1'b1;
        while (1) begin
            @(negedge clk_apb);
            cyc++;
            if (pready === 1'b1) begin
                rdata = prdata; err = pslverr;
                break;
            end
            if (cyc >= 100) begin
                check("apb_wait_budget", 32'd0, 32'd1);
                break;
            end
            @(posedge clk_apb); #1;
        end
        @(posedge clk_apb); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        bit          er;
        int          cyc, n0, r0;

        repeat (3) @(posedge clk_apb);
        #1 rstn = 1'b1;
        check("reset_item_count", 32'(item_count), 32'd0);
        check("reset_prdata", prdata, 32'd0);

        // ITEM_COUNT write/readback and clamp
        apb(1'b1, 'h0000, 32'd5, rd, er, cyc);
        check("cnt_wr_latency", 32'(cyc), 32'd2);
        apb(1'b0, 'h0000, 32'd0, rd, er, cyc);
        check("cnt_rd_value", rd, 32'd5);
        check("cnt_rd_err", 32'(er), 32'd0);
        check("cnt_rd_latency", 32'(cyc), 32'd2);
        apb(1'b1, 'h0000, 32'd2000, rd, er, cyc);
        apb(1'b0, 'h0000, 32'd0, rd, er, cyc);
        check("cnt_clamp", rd, 32'd1024);
        apb(1'b1, 'h0000, 32'd5, rd, er, cyc);

        // Memory writes and reads
        cfg_mode = 1'b1;
        n0 = n_wr;
        apb(1'b1, 'h0108, 32'hA5A5_0003, rd, er, cyc);
        check("mem_wr_pulses", 32'(n_wr - n0), 32'd1);
        check("mem_wr_err", 32'(er), 32'd0);
        check("mem_wr_latency", 32'(cyc), 32'd2);
        check("mem_wr_stored", tb_mem[2], 32'hA5A5_0003);
        apb(1'b1, 'h0100, 32'h0000_1111, rd, er, cyc);
        apb(1'b1, 'h0110, 32'hCAFE_0004, rd, er, cyc);
        rd_delay = 3;
        apb(1'b0, 'h0108, 32'd0, rd, er, cyc);
        check("mem_rd_value", rd, 32'hA5A5_0003);
        check("mem_rd_latency", 32'(cyc), 32'd5);
        rd_delay = 1;
        apb(1'b0, 'h0100, 32'd0, rd, er, cyc);
        check("mem_rd_fast", rd, 32'h0000_1111);
        check("mem_rd_fast_latency", 32'(cyc), 32'd3);
        rd_delay = TIMEOUT;
        apb(1'b0, 'h0110, 32'd0, rd, er, cyc);
        check("mem_rd_boundary_value", rd, 32'hCAFE_0004);
        check("mem_rd_boundary_err", 32'(er), 32'd0);
        check("mem_rd_boundary_latency", 32'(cyc), 32'(2 + TIMEOUT));

        // Error accesses: write-protected, out of range, misaligned
        cfg_mode = 1'b0;
        n0 = n_rd + n_wr;
        apb(1'b1, 'h0100, 32'hFFFF_FFFF, rd, er, cyc);
        check("err_protect", 32'(er), 32'd1);
        apb(1'b0, 'h0114, 32'd0, rd, er, cyc);
        check("err_range", 32'(er), 32'd1);
        apb(1'b0, 'h0102, 32'd0, rd, er, cyc);
        check("err_align", 32'(er), 32'd1);
        check("err_latency", 32'(cyc), 32'd2);
        check("err_no_strobes", 32'(n_rd + n_wr - n0), 32'd0);
        apb(1'b0, 'h0004, 32'd0, rd, er, cyc);
        check("status_err3", rd, 32'd3);

        // Read timeout, late valid ignored, STATUS clear
        rd_delay = 0;
        apb(1'b0, 'h0100, 32'd0, rd, er, cyc);
        check("timeout_err", 32'(er), 32'd1);
        check("timeout_prdata", rd, 32'd0);
        check("timeout_latency", 32'(cyc), 32'(2 + TIMEOUT));
        late_req++;
        repeat (3) @(posedge clk_apb);
        apb(1'b0, 'h0004, 32'd0, rd, er, cyc);
        check("status_timeout", rd, 32'h0000_0104);
        apb(1'b1, 'h0004, 32'd0, rd, er, cyc);
        apb(1'b0, 'h0004, 32'd0, rd, er, cyc);
        check("status_cleared", rd, 32'd0);

        // psel without penable starts nothing
        n0 = n_rd + n_wr; r0 = n_resp;
        @(posedge clk_apb); #1;
        psel = 1'b1; penable = 1'b0; paddr = 15'h0108; pwrite = 1'b0;
        repeat (5) @(posedge clk_apb);
        #1 psel = 1'b0;
        repeat (2) @(posedge clk_apb);
        check("setup_only_strobes", 32'(n_rd + n_wr - n0), 32'd0);
        check("setup_only_resp", 32'(n_resp - r0), 32'd0);

        // Abort during RD_WAIT, then a normal read
        rd_delay = 6; r0 = n_resp; n0 = n_rd;
        @(posedge clk_apb); #1;
        psel = 1'b1; penable = 1'b0; paddr = 15'h0108; pwrite = 1'b0;
        @(posedge clk_apb); #1;
        penable = 1'b1;
        repeat (3) @(posedge clk_apb);
        #1 psel = 1'b0; penable = 1'b0;
        repeat (10) @(posedge clk_apb);
        check("abort_strobe", 32'(n_rd - n0), 32'd1);
        check("abort_no_resp", 32'(n_resp - r0), 32'd0);
        rd_delay = 2;
        apb(1'b0, 'h0108, 32'd0, rd, er, cyc);
        check("after_abort_value", rd, 32'hA5A5_0003);
        check("after_abort_err", 32'(er), 32'd0);

        // err_cnt saturation
        for (int i = 0; i < 260; i++) apb(1'b0, 'h0102, 32'd0, rd, er, cyc);
        apb(1'b0, 'h0004, 32'd0, rd, er, cyc);
        check("err_saturate", rd, 32'h0000_00FF);

        // Asynchronous reset in the middle of RD_WAIT
        rd_delay = 0;
        @(posedge clk_apb); #1;
        psel = 1'b1; penable = 1'b0; paddr = 15'h0100; pwrite = 1'b0;
        @(posedge clk_apb); #1;
        penable = 1'b1;
        repeat (3) @(posedge clk_apb);
        #3 rstn = 1'b0;
        #1;
        check("async_prdata", prdata, 32'd0);
        check("async_pready", 32'(pready), 32'd0);
        check("async_pslverr", 32'(pslverr), 32'd0);
        check("async_rd_en", 32'(cfg_read_en), 32'd0);
        check("async_rd_addr", 32'(cfg_read_addr), 32'd0);
        check("async_wr_en", 32'(cfg_write_en), 32'd0);
        check("async_wr_addr", 32'(cfg_write_addr), 32'd0);
        check("async_wr_data", cfg_write_data, 32'd0);
        check("async_item_count", 32'(item_count), 32'd0);
        psel = 1'b0; penable = 1'b0;
        @(posedge clk_apb); #1 rstn = 1'b1;
        apb(1'b0, 'h0000, 32'd0, rd, er, cyc);
        check("post_reset_count", rd, 32'd0);
        apb(1'b0, 'h0004, 32'd0, rd, er, cyc);
        check("post_reset_status", rd, 32'd0);

        repeat (2) @(posedge clk_apb);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
